// File: rtl/sr_pkg.sv
// Shared status-register definitions: bit positions, width and reset value
// used by the update unit and the SR module.
package sr_pkg;
  localparam int SR_W = 8;
  localparam int SR_C = 0;
  localparam int SR_Z = 1;
  localparam int SR_N = 2;
  localparam int SR_V = 3;
  localparam int SR_I = 4;
  localparam logic [SR_W-1:0] SR_RESET = 8'h00;
endpackage

// File: rtl/sr_save_stack.sv
// LIFO of saved status bytes for interrupt entry/return. Ignores push when full
// and pop when empty; error reporting is left to the caller.
module sr_save_stack
  import sr_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = SR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(DEPTH);
  localparam logic [SP_W-1:0] SP_ONE  = SP_W'(1);

  logic [SP_W-1:0] sp_reg, sp_next;
  logic [W-1:0]    mem_reg [DEPTH];
  logic [IDX_W-1:0] rd_idx;

  assign empty  = (sp_reg == '0);
  assign full   = (sp_reg == SP_FULL);
  // The top entry must be visible in the same cycle as the pop, so the
  // read is taken straight from the small register array.
  assign rd_idx = IDX_W'(sp_reg - SP_ONE);
  assign dout   = mem_reg[rd_idx];

  always_comb begin
    sp_next = sp_reg;
    if (push && !full)
      sp_next = sp_reg + SP_ONE;
    else if (pop && !empty)
      sp_next = sp_reg - SP_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sp_reg <= '0;
    else
      sp_reg <= sp_next;
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !full)
      mem_reg[sp_reg[IDX_W-1:0]] <= din;
  end
endmodule

// File: rtl/sr_update_unit.sv
// Next-status-byte generation: ALU flags, bit set/clear and interrupt save/restore,
// keeping the authoritative status copy so back-to-back updates never see stale SR data.
module sr_update_unit
  import sr_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic [3:0]        flag_mask,
  input  logic              bit_set,
  input  logic              bit_clr,
  input  logic [2:0]        bit_idx,
  input  logic              int_push,
  input  logic              int_pop,
  input  logic              err_clr,
  output logic [SR_W-1:0]   SRSet,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_ovf,
  output logic              stack_unf,
  output logic              cmd_conflict
);
  logic [SR_W-1:0] sr_q, sr_next;
  logic [SR_W-1:0] stack_top;
  logic            st_push, st_pop;
  logic            ovf_set, unf_set;
  logic            bit_op;
  logic            conflict_next;
  logic [3:0]      cmd_classes;
  logic            ovf_reg, unf_reg, conflict_reg;

  sr_save_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (SR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (st_push),
    .pop   (st_pop),
    .din   (sr_q),
    .dout  (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  assign bit_op        = bit_set | bit_clr;
  assign cmd_classes   = {int_pop, int_push, bit_op, alu_valid};
  assign conflict_next = ($countones(cmd_classes) > 1);

  // Strict priority chain: pop, push, bit op, ALU. Lower classes are dropped.
  always_comb begin
    sr_next = sr_q;
    st_push = 1'b0;
    st_pop  = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (int_pop) begin
      if (!stack_empty) begin
        st_pop  = 1'b1;
        sr_next = stack_top;
      end else begin
        unf_set = 1'b1;
      end
    end else if (int_push) begin
      if (!stack_full)
        st_push = 1'b1;
      else
        ovf_set = 1'b1;
      sr_next[SR_I] = 1'b0;
    end else if (bit_op) begin
      sr_next[bit_idx] = bit_clr ? 1'b0 : 1'b1;
    end else if (alu_valid) begin
      if (flag_mask[0]) sr_next[SR_C] = alu_carry;
      if (flag_mask[1]) sr_next[SR_Z] = (alu_result == '0);
      if (flag_mask[2]) sr_next[SR_N] = alu_result[DATA_W-1];
      if (flag_mask[3]) sr_next[SR_V] = alu_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q         <= SR_RESET;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
      conflict_reg <= 1'b0;
    end else begin
      sr_q         <= sr_next;
      conflict_reg <= conflict_next;
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (err_clr)
        ovf_reg <= 1'b0;
      if (unf_set)
        unf_reg <= 1'b1;
      else if (err_clr)
        unf_reg <= 1'b0;
    end
  end

  assign SRSet        = sr_q;
  assign stack_ovf    = ovf_reg;
  assign stack_unf    = unf_reg;
  assign cmd_conflict = conflict_reg;
endmodule

// File: tb/tb_sr_update_unit.sv
// Directed bench for sr_update_unit with hand-computed status bytes.
module tb_sr_update_unit;
  logic       clk = 1'b0;
  logic       rst;
  logic       alu_valid;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_ovf;
  logic [3:0] flag_mask;
  logic       bit_set;
  logic       bit_clr;
  logic [2:0] bit_idx;
  logic       int_push;
  logic       int_pop;
  logic       err_clr;
  logic [7:0] SRSet;
  logic       stack_empty, stack_full, stack_ovf, stack_unf, cmd_conflict;
  logic [7:0] srdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_update_unit #(.DATA_W(8), .STACK_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_valid    (alu_valid),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_ovf      (alu_ovf),
    .flag_mask    (flag_mask),
    .bit_set      (bit_set),
    .bit_clr      (bit_clr),
    .bit_idx      (bit_idx),
    .int_push     (int_push),
    .int_pop      (int_pop),
    .err_clr      (err_clr),
    .SRSet        (SRSet),
    .stack_empty  (stack_empty),
    .stack_full   (stack_full),
    .stack_ovf    (stack_ovf),
    .stack_unf    (stack_unf),
    .cmd_conflict (cmd_conflict)
  );

  // Stand-in for the downstream SR module: one register stage.
  always_ff @(posedge clk) begin
    if (rst) srdata <= 8'h00;
    else     srdata <= SRSet;
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end else begin
      $display("ok   %s = %02h", tag, got);
    end
  endtask

  task automatic idle();
    rst = 0; alu_valid = 0; alu_result = 0; alu_carry = 0; alu_ovf = 0;
    flag_mask = 0; bit_set = 0; bit_clr = 0; bit_idx = 0;
    int_push = 0; int_pop = 0; err_clr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick();
  endtask

  task automatic do_alu(input logic [7:0] res, input logic c, input logic v, input logic [3:0] m);
    alu_valid = 1; alu_result = res; alu_carry = c; alu_ovf = v; flag_mask = m; tick();
  endtask

  task automatic do_set(input logic [2:0] idx);
    bit_set = 1; bit_idx = idx; tick();
  endtask

  task automatic do_push();
    int_push = 1; tick();
  endtask

  task automatic do_pop();
    int_pop = 1; tick();
  endtask

  initial begin
    logic [7:0] lifo [4];
    lifo[0] = 8'h0F; lifo[1] = 8'h07; lifo[2] = 8'h03; lifo[3] = 8'h01;

    do_reset();
    chk("rst_sr", SRSet, 8'h00);
    chk("rst_empty", {7'd0, stack_empty}, 8'h01);
    chk("rst_full", {7'd0, stack_full}, 8'h00);
    chk("rst_errs", {6'd0, stack_ovf, stack_unf}, 8'h00);
    chk("rst_conflict", {7'd0, cmd_conflict}, 8'h00);

    // Zero result with carry, all flags enabled.
    do_alu(8'h00, 1'b1, 1'b0, 4'b1111);
    chk("alu_zc_srset", SRSet, 8'h03);
    tick();
    chk("alu_zc_srdata", srdata, 8'h03);

    // Back-to-back partial updates.
    do_reset();
    do_alu(8'h80, 1'b0, 1'b0, 4'b0100);
    chk("b2b_first", SRSet, 8'h04);
    do_alu(8'h00, 1'b0, 1'b0, 4'b0010);
    chk("b2b_second", SRSet, 8'h06);
    do_alu(8'h55, 1'b1, 1'b1, 4'b0000);
    chk("alu_mask0_hold", SRSet, 8'h06);
    do_alu(8'h01, 1'b0, 1'b1, 4'b1000);
    chk("alu_v_only", SRSet, 8'h0E);

    // Interrupt entry/return.
    do_reset();
    do_set(3'd4);
    chk("set_i", SRSet, 8'h10);
    do_push();
    chk("push_clears_i", SRSet, 8'h00);
    do_set(3'd7);
    chk("set_user7", SRSet, 8'h80);
    do_pop();
    chk("pop_restore", SRSet, 8'h10);
    chk("pop_empty", {7'd0, stack_empty}, 8'h01);

    // Fill, overflow, drain, underflow.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      do_set(3'(k));
      do_push();
    end
    chk("fill_sr", SRSet, 8'h0F);
    chk("fill_full", {7'd0, stack_full}, 8'h01);
    chk("fill_ovf_clear", {7'd0, stack_ovf}, 8'h00);
    do_set(3'd4);
    do_push();
    chk("ovf_sr_i_cleared", SRSet, 8'h0F);
    chk("ovf_flag", {7'd0, stack_ovf}, 8'h01);
    chk("ovf_still_full", {7'd0, stack_full}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      do_pop();
      chk($sformatf("lifo_pop%0d", k), SRSet, lifo[k]);
    end
    chk("drain_empty", {7'd0, stack_empty}, 8'h01);
    chk("drain_unf_clear", {7'd0, stack_unf}, 8'h00);
    int_pop = 1; err_clr = 1; tick();
    chk("unf_sr_hold", SRSet, 8'h01);
    chk("unf_set_beats_clr", {7'd0, stack_unf}, 8'h01);
    chk("ovf_cleared_by_clr", {7'd0, stack_ovf}, 8'h00);
    err_clr = 1; tick();
    chk("unf_cleared", {7'd0, stack_unf}, 8'h00);

    // Conflicting command classes.
    do_set(3'd6);
    do_push();
    bit_clr = 1; bit_idx = 3'd6; tick();
    chk("clr_user6", SRSet, 8'h01);
    int_pop = 1; bit_set = 1; bit_idx = 3'd2;
    alu_valid = 1; alu_result = 8'h00; flag_mask = 4'b1111; tick();
    chk("conflict_pop_only", SRSet, 8'h41);
    chk("conflict_pulse", {7'd0, cmd_conflict}, 8'h01);
    tick();
    chk("conflict_drop", {7'd0, cmd_conflict}, 8'h00);
    bit_clr = 1; bit_idx = 3'd6; tick();
    bit_set = 1; bit_clr = 1; bit_idx = 3'd0; tick();
    chk("setclr_clr_wins", SRSet, 8'h00);
    chk("setclr_no_conflict", {7'd0, cmd_conflict}, 8'h00);

    // Reset overrides a push mid-sequence.
    do_push();
    do_push();
    do_alu(8'h00, 1'b1, 1'b1, 4'b1011);
    do_set(3'd4);
    do_set(3'd7);
    chk("pre_rst_sr", SRSet, 8'h9B);
    chk("pre_rst_not_empty", {7'd0, stack_empty}, 8'h00);
    rst = 1; int_push = 1; tick();
    chk("rst_push_sr", SRSet, 8'h00);
    chk("rst_push_empty", {7'd0, stack_empty}, 8'h01);
    chk("rst_push_errs", {5'd0, stack_ovf, stack_unf, cmd_conflict}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
